rps_round_ctrl: RTL and testbench



---
 rtl/rps_round_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_rps_round_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: debounced start key, one round per press, judging, saturating BCD scores.
// Defining RPS_MATCH_LIMIT_EN adds WIN_TARGET and a match_over output that freezes play once a score reaches it.
module rps_round_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef RPS_MATCH_LIMIT_EN
    ,
    parameter int WIN_TARGET = 5
`endif
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_n,
    input  logic [1:0] user_choice,
    input  logic [1:0] com_choice,
    output logic       round_valid,
    output logic       round_err,
    output logic       user_win,
    output logic       com_win,
    output logic       draw,
    output logic [3:0] last_pair,
    output logic [7:0] user_score,
    output logic [7:0] com_score,
    output logic       busy
`ifdef RPS_MATCH_LIMIT_EN
    ,
    output logic       match_over
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        JUDGE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // BCD increment that sticks at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = 8'h99;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Returns {user_win, com_win, draw}
    function automatic logic [2:0] judge(input logic [1:0] u, input logic [1:0] c);
        logic [2:0] r;
        if (u == c) begin
            r = 3'b001;
        end else if ((u == 2'b00 && c == 2'b01) || (u == 2'b01 && c == 2'b10) ||
                     (u == 2'b10 && c == 2'b00)) begin
            r = 3'b100;
        end else begin
            r = 3'b010;
        end
        return r;
    endfunction

    logic             sync1_r, sync2_r, acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             flip_s, fall_s, rise_s;
    state_t           state_r;
    logic [1:0]       cap_user_r, cap_com_r;
    logic [2:0]       flags_s;
    logic             invalid_s;
    logic [7:0]       user_inc_s, com_inc_s;
    logic             hit_s, lock_s;
    logic             round_valid_r, round_err_r, user_win_r, com_win_r, draw_r, busy_r;
    logic [3:0]       last_pair_r;
    logic [7:0]       user_score_r, com_score_r;

    // The accepted level flips on the edge the counter would reach DEBOUNCE_CYCLES
    assign flip_s     = (sync2_r != acc_r) && (cnt_r == CNT_LAST);
    assign fall_s     = flip_s && !sync2_r;
    assign rise_s     = flip_s && sync2_r;
    assign flags_s    = judge(cap_user_r, cap_com_r);
    assign invalid_s  = (cap_user_r == 2'b11) || (cap_com_r == 2'b11);
    assign user_inc_s = bcd_inc(user_score_r);
    assign com_inc_s  = bcd_inc(com_score_r);

`ifdef RPS_MATCH_LIMIT_EN
    localparam logic [7:0] TARGET_BCD = {4'(WIN_TARGET / 10), 4'(WIN_TARGET % 10)};
    logic match_over_r;

    assign hit_s  = (flags_s[2] && (user_inc_s == TARGET_BCD)) ||
                    (flags_s[1] && (com_inc_s == TARGET_BCD));
    assign lock_s = match_over_r;
    assign match_over = match_over_r;

    // Sticky end-of-match flag, cleared only by reset_n
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_over_r <= 1'b0;
        end else if (state_r == JUDGE && !invalid_s && hit_s) begin
            match_over_r <= 1'b1;
        end else begin
            match_over_r <= match_over_r;
        end
    end
`else
    assign hit_s  = 1'b0;
    assign lock_s = 1'b0;
`endif

    // Start key synchroniser and debouncer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            acc_r   <= 1'b1;
            cnt_r   <= '0;
        end else begin
            sync1_r <= start_n;
            sync2_r <= sync1_r;
            if (sync2_r != acc_r) begin
                if (cnt_r == CNT_LAST) begin
                    acc_r <= sync2_r;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Round FSM with registered result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            cap_user_r    <= 2'b00;
            cap_com_r     <= 2'b00;
            round_valid_r <= 1'b0;
            round_err_r   <= 1'b0;
            user_win_r    <= 1'b0;
            com_win_r     <= 1'b0;
            draw_r        <= 1'b0;
            last_pair_r   <= 4'b0000;
            user_score_r  <= 8'h00;
            com_score_r   <= 8'h00;
            busy_r        <= 1'b0;
        end else begin
            round_valid_r <= 1'b0;
            round_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fall_s && !lock_s) begin
                        state_r <= CAPTURE;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    cap_user_r <= user_choice;
                    cap_com_r  <= com_choice;
                    state_r    <= JUDGE;
                end
                JUDGE: begin
                    if (invalid_s) begin
                        round_err_r <= 1'b1;
                        state_r     <= RELEASE;
                    end else begin
                        round_valid_r <= 1'b1;
                        {user_win_r, com_win_r, draw_r} <= flags_s;
                        last_pair_r <= {cap_com_r, cap_user_r};
                        if (flags_s[2]) begin
                            user_score_r <= user_inc_s;
                        end else if (flags_s[1]) begin
                            com_score_r <= com_inc_s;
                        end else begin
                            user_score_r <= user_score_r;
                        end
                        // A finished match parks in IDLE without waiting for release
                        if (hit_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (rise_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= RELEASE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign round_valid = round_valid_r;
    assign round_err   = round_err_r;
    assign user_win    = user_win_r;
    assign com_win     = com_win_r;
    assign draw        = draw_r;
    assign last_pair   = last_pair_r;
    assign user_score  = user_score_r;
    assign com_score   = com_score_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Scoreboard bench for rps_round_ctrl with DEBOUNCE_CYCLES = 4: stimulus pushes expected round results,
// a negedge monitor pops and compares them whenever a round strobe appears.
module tb_rps_round_ctrl;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_n = 1'b1;
    logic [1:0] user_choice = 2'b00;
    logic [1:0] com_choice = 2'b00;
    logic       round_valid, round_err, user_win, com_win, draw, busy;
    logic [3:0] last_pair;
    logic [7:0] user_score, com_score;
`ifdef RPS_MATCH_LIMIT_EN
    logic       match_over;
`endif

    rps_round_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start_n(start_n),
        .user_choice(user_choice),
        .com_choice(com_choice),
        .round_valid(round_valid),
        .round_err(round_err),
        .user_win(user_win),
        .com_win(com_win),
        .draw(draw),
        .last_pair(last_pair),
        .user_score(user_score),
        .com_score(com_score),
        .busy(busy)
`ifdef RPS_MATCH_LIMIT_EN
        ,
        .match_over(match_over)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [24:0] v;
        int          exp_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_strobes = 0;
    int         n_user = 0;
    int         n_com = 0;
    logic [2:0] m_flags = 3'b000;
    logic [3:0] m_pair = 4'b0000;

    function automatic logic [7:0] to_bcd(input int n);
        int k;
        k = (n > 99) ? 99 : n;
        return {4'(k / 10), 4'(k % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // outcome: 0 draw, 1 user win, 2 com win, 3 rejected
    task automatic push_round(input logic [1:0] u, input logic [1:0] c, input int outcome, input int ecyc);
        exp_t e;
        logic rv, re;
        rv = 1'b1;
        re = 1'b0;
        case (outcome)
            0: m_flags = 3'b001;
            1: begin m_flags = 3'b100; n_user++; end
            2: begin m_flags = 3'b010; n_com++; end
            default: begin rv = 1'b0; re = 1'b1; end
        endcase
        if (outcome < 3) m_pair = {c, u};
        e.v = {rv, re, m_flags, m_pair, to_bcd(n_user), to_bcd(n_com)};
        e.exp_cyc = ecyc;
        exp_q.push_back(e);
    endtask

    // Entered and left #1 after a rising edge; start_n held low for hold cycles, then high for rel
    task automatic do_round(input logic [1:0] u, input logic [1:0] c, input int outcome, input int hold,
                            input int rel, input bit lat, input int chg_at, input logic [1:0] chg_u);
        logic [1:0] judged;
        judged = (chg_at > 0 && chg_at <= 6) ? chg_u : u;
        user_choice = u;
        com_choice = c;
        start_n = 1'b0;
        push_round(judged, c, outcome, lat ? cyc + 2 + DEB + 2 : -1);
        for (int i = 1; i <= hold; i++) begin
            @(posedge clock); #1;
            if (i == chg_at) user_choice = chg_u;
        end
        start_n = 1'b1;
        repeat (rel) begin @(posedge clock); #1; end
    endtask

    // Monitor: compare every round strobe against the head of the scoreboard
    always @(negedge clock) begin
        if (reset_n && (round_valid || round_err)) begin
            exp_t e;
            n_strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe valid=%0b err=%0b at cycle %0d", round_valid, round_err, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({round_valid, round_err, user_win, com_win, draw, last_pair, user_score, com_score} !== e.v) begin
                    errors++;
                    $display("FAIL round_result actual=%0h required=%0h",
                             {round_valid, round_err, user_win, com_win, draw, last_pair, user_score, com_score}, e.v);
                end
                if (e.exp_cyc >= 0) begin
                    checks++;
                    if (cyc != e.exp_cyc) begin
                        errors++;
                        $display("FAIL round_latency actual=%0d required=%0d", cyc, e.exp_cyc);
                    end
                end
            end
        end
    end

    initial begin
        int s0;
        logic [1:0] tu[9];
        logic [1:0] tc[9];
        int         to[9];
        tu = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        tc = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        to = '{0, 1, 2, 2, 0, 1, 1, 2, 0};

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        check("reset_outputs", {round_valid, round_err, user_win, com_win, draw, last_pair, user_score, com_score}, 32'h0);
        check("reset_busy", busy, 32'h0);
        s0 = n_strobes;
        repeat (100) begin @(posedge clock); #1; end
        check("idle_no_strobe", n_strobes, s0);

        // first judged win: rock vs scissor, latency checked by the monitor
        do_round(2'b00, 2'b01, 1, 10, 12, 1'b1, 0, 2'b00);
        check("idle_after_release_busy", busy, 32'h0);

        foreach (tu[i]) do_round(tu[i], tc[i], to[i], 10, 12, 1'b1, 0, 2'b00);

        // rejected rounds leave flags, pair and scores alone
        do_round(2'b00, 2'b11, 3, 10, 12, 1'b1, 0, 2'b00);
        do_round(2'b11, 2'b10, 3, 10, 12, 1'b1, 0, 2'b00);

        // choice change just after capture is ignored; change during capture is used
        do_round(2'b10, 2'b00, 1, 10, 12, 1'b1, 7, 2'b01);
        do_round(2'b10, 2'b00, 2, 10, 12, 1'b1, 6, 2'b01);

        // bouncing key: 2-cycle pulses never qualify
        s0 = n_strobes;
        repeat (10) begin
            start_n = 1'b0;
            repeat (2) begin @(posedge clock); #1; end
            start_n = 1'b1;
            repeat (2) begin @(posedge clock); #1; end
        end
        repeat (10) begin @(posedge clock); #1; end
        check("bounce_no_round", n_strobes, s0);

        // long hold yields one round; a 3-cycle release is not a release
        do_round(2'b01, 2'b10, 1, 200, 3, 1'b0, 0, 2'b00);
        check("hold_one_round", n_strobes, s0 + 1);
        check("hold_busy", busy, 32'h1);
        start_n = 1'b0;
        repeat (30) begin @(posedge clock); #1; end
        check("short_release_no_round", n_strobes, s0 + 1);
        start_n = 1'b1;
        repeat (DEB) begin @(posedge clock); #1; end
        do_round(2'b10, 2'b01, 2, 10, 12, 1'b0, 0, 2'b00);
        check("after_min_release_rounds", n_strobes, s0 + 2);

        // BCD carry and saturation via repeated user wins
        while (n_user < 101) do_round(2'b00, 2'b01, 1, 10, 12, 1'b1, 0, 2'b00);
        check("user_saturated", user_score, 32'h99);
        check("com_unaffected", com_score, {24'h0, to_bcd(n_com)});

        // async reset while the key is held in RELEASE
        user_choice = 2'b00;
        com_choice = 2'b10;
        start_n = 1'b0;
        push_round(2'b00, 2'b10, 2, cyc + 2 + DEB + 2);
        repeat (12) begin @(posedge clock); #1; end
        check("pre_reset_busy", busy, 32'h1);
        #3;
        reset_n = 1'b0;
        start_n = 1'b1;
        #1;
        check("async_reset_outputs", {round_valid, round_err, user_win, com_win, draw, last_pair, user_score, com_score}, 32'h0);
        check("async_reset_busy", busy, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        n_user = 0;
        n_com = 0;
        m_flags = 3'b000;
        m_pair = 4'b0000;
        s0 = n_strobes;
        repeat (20) begin @(posedge clock); #1; end
        check("post_reset_no_strobe", n_strobes, s0);
        do_round(2'b10, 2'b00, 1, 10, 12, 1'b1, 0, 2'b00);

        repeat (5) begin @(posedge clock); #1; end
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
